// File: rtl/mem_responder_w_mask.sv
// mem_responder_w_mask
// Single-port 32-bit memory responder for the masked memory interface.
// Accepts one byte-masked read or write at a time, commits writes on the
// accepting edge, and answers with a one-cycle mem_resp pulse LATENCY cycles
// after acceptance. Malformed requests, and requests arriving while a
// response is pending, raise a sticky error flag.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   mem_addr   byte address of the request
//   mem_rmask  read byte enables (nonzero = read request)
//   mem_wmask  write byte enables (nonzero = write request)
//   mem_wdata  write data, byte i on bits [8i+7:8i]
//   mem_rdata  read data, 0 whenever mem_resp is low
//   mem_resp   one-cycle response pulse
//   busy       a request is outstanding and not yet answered
//   error      sticky protocol-error flag, cleared only by rst
module mem_responder_w_mask #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic        error
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [31:0]             hold_r;
    logic [31:0]             mem_r [DEPTH];

    logic                    req_s;
    logic                    accept_s;
    logic                    malformed_s;
    logic                    wr_en_s;
    logic [31:0]             offset_s;
    logic [DEPTH_LOG2-1:0]   idx_s;
    logic [31:0]             resp_data_s;

    // Expand a 4-bit byte enable into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Request decode, address check and response-data selection
    always_comb begin
        req_s    = (mem_rmask != 4'h0) || (mem_wmask != 4'h0);
        accept_s = req_s && ((state_r == ST_IDLE) || (state_r == ST_RESP));
        // Unsigned wrap makes addresses below BASE_ADDR look far out of range.
        offset_s = mem_addr - BASE_ADDR;
        idx_s    = offset_s[DEPTH_LOG2+1:2];
        malformed_s = ((mem_rmask != 4'h0) && (mem_wmask != 4'h0))
                   || (mem_addr[1:0] != 2'b00)
                   || (offset_s >= SPAN);
        wr_en_s  = accept_s && !malformed_s && (mem_wmask != 4'h0) && !rst;
        if (malformed_s || (mem_wmask != 4'h0)) begin
            resp_data_s = 32'h0;
        end else begin
            resp_data_s = mem_r[idx_s] & byte_mask(mem_rmask);
        end
        // In RESP the block stays occupied only if it takes a new request.
        busy = (state_r == ST_WAIT) || ((state_r == ST_RESP) && req_s);
    end

    // Control FSM: acceptance, latency count, response pulse and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            hold_r    <= 32'h0;
            mem_resp  <= 1'b0;
            mem_rdata <= 32'h0;
            error     <= 1'b0;
        end else begin
            mem_resp  <= 1'b0;
            mem_rdata <= 32'h0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (accept_s) begin
                        hold_r <= resp_data_s;
                        cnt_r  <= 4'd1;
                        if (malformed_s) begin
                            error <= 1'b1;
                        end
                        // With a one-cycle latency the answer goes out on the
                        // very next cycle, so WAIT is skipped entirely.
                        if (LATENCY == 1) begin
                            state_r   <= ST_RESP;
                            mem_resp  <= 1'b1;
                            mem_rdata <= resp_data_s;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                    end
                end
                ST_WAIT: begin
                    // Requests in WAIT are dropped unanswered.
                    if (req_s) begin
                        error <= 1'b1;
                    end
                    if (cnt_r == LAST_CNT) begin
                        state_r   <= ST_RESP;
                        cnt_r     <= 4'd0;
                        mem_resp  <= 1'b1;
                        mem_rdata <= hold_r;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Array write port: masked bytes commit on the accepting edge; never reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    mem_r[idx_s][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder_w_mask.sv
// Bench for mem_responder_w_mask: two instances (LATENCY 3 and 1) run against
// a cycle-level reference model that tracks pending responses by due cycle,
// plus directed checks of the documented scenarios.
module tb_mem_responder_w_mask;

    localparam logic [31:0] BASE = 32'h1eceb000;
    localparam int          LAT0 = 3;
    localparam int          LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic [31:0] addr_s  [2];
    logic [3:0]  rmask_s [2];
    logic [3:0]  wmask_s [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        resp_s  [2];
    logic        busy_s  [2];
    logic        error_s [2];

    mem_responder_w_mask #(.DEPTH_LOG2(10), .LATENCY(LAT0), .BASE_ADDR(BASE)) u_dut_l3 (
        .clk(clk), .rst(rst_s[0]), .mem_addr(addr_s[0]), .mem_rmask(rmask_s[0]),
        .mem_wmask(wmask_s[0]), .mem_wdata(wdata_s[0]), .mem_rdata(rdata_s[0]),
        .mem_resp(resp_s[0]), .busy(busy_s[0]), .error(error_s[0])
    );

    mem_responder_w_mask #(.DEPTH_LOG2(10), .LATENCY(LAT1), .BASE_ADDR(BASE)) u_dut_l1 (
        .clk(clk), .rst(rst_s[1]), .mem_addr(addr_s[1]), .mem_rmask(rmask_s[1]),
        .mem_wmask(wmask_s[1]), .mem_wdata(wdata_s[1]), .mem_rdata(rdata_s[1]),
        .mem_resp(resp_s[1]), .busy(busy_s[1]), .error(error_s[1])
    );

    int n_tests = 0;
    int n_fails = 0;
    int cyc     = 0;

    // Reference model state, one slot per instance
    int          lat_m   [2] = '{LAT0, LAT1};
    bit          pend_m  [2];
    int          due_m   [2];
    logic [31:0] pdata_m [2];
    bit          pchk_m  [2];
    bit          err_m   [2];
    bit   [31:0] mem_m   [2][1024];
    bit   [3:0]  kn_m    [2][1024];
    int          resp_cnt   [2];
    logic [31:0] last_rdata [2];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One model cycle: compare outputs against expectations, then absorb this cycle's inputs.
    task automatic model_step(input int k);
        bit          exp_resp, in_wait, req, bad;
        logic [31:0] off, word;
        int          idx;
        string       sfx;
        sfx      = $sformatf("_l%0d", lat_m[k]);
        exp_resp = pend_m[k] && (due_m[k] == cyc);
        in_wait  = pend_m[k] && (cyc < due_m[k]);
        req      = (rmask_s[k] != 4'h0) || (wmask_s[k] != 4'h0);
        check_eq({"resp", sfx}, {31'b0, resp_s[k]}, {31'b0, exp_resp});
        if (!exp_resp) begin
            check_eq({"rdata_quiet", sfx}, rdata_s[k], 32'h0);
        end else if (pchk_m[k]) begin
            check_eq({"rdata", sfx}, rdata_s[k], pdata_m[k]);
        end
        check_eq({"error", sfx}, {31'b0, error_s[k]}, {31'b0, err_m[k]});
        if (in_wait) begin
            check_eq({"busy_wait", sfx}, {31'b0, busy_s[k]}, 32'h1);
        end else if (!(exp_resp && req)) begin
            check_eq({"busy_free", sfx}, {31'b0, busy_s[k]}, 32'h0);
        end
        if (resp_s[k] === 1'b1) begin
            resp_cnt[k]++;
            last_rdata[k] = rdata_s[k];
        end
        if (rst_s[k]) begin
            pend_m[k] = 1'b0;
            err_m[k]  = 1'b0;
        end else if (req && in_wait) begin
            err_m[k] = 1'b1;
        end else if (req) begin
            off = addr_s[k] - BASE;
            bad = ((rmask_s[k] != 4'h0) && (wmask_s[k] != 4'h0))
               || (addr_s[k][1:0] != 2'b00) || (off >= 32'd4096);
            idx        = int'(off[11:2]);
            pend_m[k]  = 1'b1;
            due_m[k]   = cyc + lat_m[k];
            pdata_m[k] = 32'h0;
            pchk_m[k]  = 1'b1;
            if (bad) begin
                err_m[k] = 1'b1;
            end else if (wmask_s[k] != 4'h0) begin
                word = mem_m[k][idx];
                for (int i = 0; i < 4; i++) begin
                    if (wmask_s[k][i]) word[8*i +: 8] = wdata_s[k][8*i +: 8];
                end
                mem_m[k][idx] = word;
                kn_m[k][idx]  = kn_m[k][idx] | wmask_s[k];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (rmask_s[k][i]) pdata_m[k][8*i +: 8] = mem_m[k][idx][8*i +: 8];
                end
                pchk_m[k] = ((rmask_s[k] & ~kn_m[k][idx]) == 4'h0);
            end
        end else if (exp_resp) begin
            pend_m[k] = 1'b0;
        end
    endtask

    // Mid-cycle sampling of both instances against the model
    always @(negedge clk) begin
        model_step(0);
        model_step(1);
        cyc++;
    end

    task automatic drive(input int k, input logic [31:0] a, input logic [3:0] r,
                         input logic [3:0] w, input logic [31:0] d);
        addr_s[k]  = a;
        rmask_s[k] = r;
        wmask_s[k] = w;
        wdata_s[k] = d;
        @(posedge clk);
        #1;
        rmask_s[k] = 4'h0;
        wmask_s[k] = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst(input int k);
        rst_s[k] = 1'b1;
        idle(1);
        rst_s[k] = 1'b0;
    endtask

    task automatic rand_op(input int k, input int gap_lo, input int gap_hi);
        int          sel, w;
        logic [31:0] a;
        logic [3:0]  m;
        sel = int'($urandom_range(0, 15));
        w   = int'($urandom_range(0, 16));
        if (w == 16) w = 1023;
        a = BASE + 32'(w * 4);
        if (sel == 0) a = a + 32'($urandom_range(1, 3));
        else if (sel == 1) a = BASE + 32'd4096 + 32'($urandom_range(0, 7) * 4);
        m = 4'($urandom_range(1, 15));
        if (sel == 2) drive(k, a, m, 4'hf, $urandom);
        else if ($urandom_range(0, 1) == 1) drive(k, a, 4'h0, m, $urandom);
        else drive(k, a, m, 4'h0, 32'h0);
        idle(int'($urandom_range(gap_lo, gap_hi)));
    endtask

    int          c0;
    logic [31:0] wd [8];

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_s[k]   = 1'b1;
            addr_s[k]  = 32'h0;
            rmask_s[k] = 4'h0;
            wmask_s[k] = 4'h0;
            wdata_s[k] = 32'h0;
            last_rdata[k] = 32'h0;
        end
        idle(3);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // LATENCY=3: seed the words used by random traffic
        for (int w = 0; w < 17; w++) begin
            drive(0, BASE + 32'((w == 16 ? 1023 : w) * 4), 4'h0, 4'hf, $urandom);
            idle(2);
        end

        // Masked write then full and partial reads
        drive(0, BASE, 4'h0, 4'hf, 32'hDEADBEEF);
        idle(2);
        drive(0, BASE, 4'h0, 4'b0010, 32'h0000AA00);
        idle(2);
        drive(0, BASE, 4'hf, 4'h0, 32'h0);
        idle(3);
        check_eq("masked_read", last_rdata[0], 32'hDEADAAEF);
        drive(0, BASE, 4'b1001, 4'h0, 32'h0);
        idle(3);
        check_eq("partial_read", last_rdata[0], 32'hDE0000EF);
        check_eq("no_error", {31'b0, error_s[0]}, 32'h0);

        for (int i = 0; i < 150; i++) rand_op(0, 1, 3);
        idle(4);

        // Read in WAIT is dropped
        pulse_rst(0);
        drive(0, BASE + 32'd4, 4'hf, 4'h0, 32'h0);
        drive(0, BASE + 32'd8, 4'hf, 4'h0, 32'h0);
        c0 = resp_cnt[0];
        idle(4);
        check_eq("wait_drop_resps", 32'(resp_cnt[0] - c0), 32'd1);
        check_eq("wait_drop_error", {31'b0, error_s[0]}, 32'h1);

        // Misaligned address
        pulse_rst(0);
        last_rdata[0] = 32'hFFFFFFFF;
        drive(0, BASE + 32'd2, 4'hf, 4'h0, 32'h0);
        idle(3);
        check_eq("misalign_rdata", last_rdata[0], 32'h0);
        check_eq("misalign_error", {31'b0, error_s[0]}, 32'h1);

        // Both masks set: no array change (model checks the read-back)
        pulse_rst(0);
        drive(0, BASE + 32'd4, 4'hf, 4'hf, 32'h12345678);
        idle(2);
        drive(0, BASE + 32'd4, 4'hf, 4'h0, 32'h0);
        idle(3);
        check_eq("both_mask_error", {31'b0, error_s[0]}, 32'h1);

        // Out of range above and below
        pulse_rst(0);
        last_rdata[0] = 32'hFFFFFFFF;
        drive(0, BASE + 32'd4096, 4'h0, 4'hf, 32'h55555555);
        idle(3);
        check_eq("oor_hi_rdata", last_rdata[0], 32'h0);
        drive(0, BASE - 32'd4, 4'h0, 4'hf, 32'h66666666);
        idle(2);
        drive(0, BASE, 4'hf, 4'h0, 32'h0);
        idle(2);
        drive(0, BASE + 32'd4092, 4'hf, 4'h0, 32'h0);
        idle(3);
        check_eq("oor_error", {31'b0, error_s[0]}, 32'h1);

        // Reset one cycle after a read: no response; earlier write survives
        pulse_rst(0);
        drive(0, BASE + 32'd8, 4'h0, 4'hf, 32'hCAFEF00D);
        idle(2);
        drive(0, BASE + 32'd8, 4'hf, 4'h0, 32'h0);
        rst_s[0] = 1'b1;
        idle(1);
        rst_s[0] = 1'b0;
        c0 = resp_cnt[0];
        idle(2 * LAT0);
        check_eq("rst_mid_read_resps", 32'(resp_cnt[0] - c0), 32'd0);
        drive(0, BASE + 32'd8, 4'hf, 4'h0, 32'h0);
        idle(3);
        check_eq("rst_keeps_write", last_rdata[0], 32'hCAFEF00D);

        // LATENCY=1: back-to-back writes, then 8 consecutive reads
        for (int w = 0; w < 8; w++) begin
            wd[w] = $urandom;
            drive(1, BASE + 32'(w * 4), 4'h0, 4'hf, wd[w]);
        end
        idle(1);
        c0 = resp_cnt[1];
        for (int w = 0; w < 8; w++) drive(1, BASE + 32'(w * 4), 4'hf, 4'h0, 32'h0);
        idle(1);
        check_eq("b2b_resps", 32'(resp_cnt[1] - c0), 32'd8);
        check_eq("b2b_last_data", last_rdata[1], wd[7]);

        for (int i = 0; i < 150; i++) rand_op(1, 0, 1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
